dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the core's load/store unit (master 0) and a secondary bus master (master 1: program loader or debug port). It sits between the core data port and `data_mem` inside `soc`. It grants one request per cycle, forwards it to the memory, and routes the one-cycle-latency response back to the granted master. The core can then run while the loader or debug port reads result words such as mem[0] and mem[1] without stalling indefinitely.

## Interface
- `ADDR_WIDTH`, 32, byte address width of both masters and the memory port
- `DATA_WIDTH`, 32, data word width; byte enables are `DATA_WIDTH/8`
- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, asynchronous and active-low
- `m0_req_i` / `m1_req_i` in 1: request valid, per master
- `m0_gnt_o` / `m1_gnt_o` out 1: request accepted this cycle
- `m0_addr_i` / `m1_addr_i` in ADDR_WIDTH: byte address
- `m0_we_i` / `m1_we_i` in 1: 1 = write, 0 = read
- `m0_be_i` / `m1_be_i` in DATA_WIDTH/8: byte enables
- `m0_wdata_i` / `m1_wdata_i` in DATA_WIDTH: write data
- `m0_rvalid_o` / `m1_rvalid_o` out 1: response valid, one cycle after grant
- `m0_rdata_o` / `m1_rdata_o` out DATA_WIDTH: read data
- `mem_req_o` out 1: memory access strobe
- `mem_we_o` out 1: memory write enable
- `mem_addr_o` out ADDR_WIDTH: memory byte address
- `mem_be_o` out DATA_WIDTH/8: memory byte enables
- `mem_wdata_o` out DATA_WIDTH: memory write data
- `mem_rdata_i` in DATA_WIDTH: memory read data, valid the cycle after `mem_req_o`

## Operation
- Grant is combinational from the `req` inputs and the priority pointer. At most one `gnt` is high per cycle.
- Only one master requests: that master is granted immediately.
- Both masters request: the master selected by `prio_q` is granted.
- After every grant, `prio_q` points to the other master (round-robin). With no grant, `prio_q` holds.
- `mem_*` outputs mux the granted master's fields. `mem_req_o` = `m0_gnt_o | m1_gnt_o`.
- With no grant, `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are 0.
- Response tracking registers:
  - `resp_valid_q`, set on any grant
  - `resp_id_q`, the granted master
  - `resp_we_q`, the granted `we`
- Next cycle, `mN_rvalid_o` = `resp_valid_q & (resp_id_q == N)`. Responses are returned for writes as well as reads.
- `mN_rdata_o` = `mem_rdata_i` when that master's rvalid is high and `resp_we_q` = 0; otherwise 0.
- Masters must hold `req`, `addr`, `we`, `be` and `wdata` stable until `gnt`. Dropping `req` before `gnt` is legal and cancels the request.

## Timing
- Grant latency 0 cycles. Response latency exactly 1 cycle after grant.
- Throughput: one access per cycle, back-to-back. Under contention each master gets every other cycle.
- Worst-case wait under contention: 1 cycle.
- A grant in cycle N+1 overlaps the response of grant N. This is legal because the response path is independent.
- Reset values:
  - `prio_q` = master 0
  - `resp_valid_q` = 0, `resp_id_q` = 0, `resp_we_q` = 0
  - all rvalid = 0, all rdata = 0
- With `rst_ni` low, all `gnt` and `mem_req_o` are forced to 0.
- Reset mid-operation: a pending response is dropped and no rvalid is issued after reset.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined:
  - `prio_q` is removed and master 1 always wins contention.
  - Master 0 can starve. This mode is used when debug access must be deterministic.
- Undefined (default): round-robin as described above.

## Structure
- `dmem_arb_pkg` holds:
  - `master_id_e` enum (`MST_CORE`=0, `MST_AUX`=1)
  - `dmem_req_t` struct (`addr`, `we`, `be`, `wdata`)
  - `NUM_MASTERS` = 2
- Sub-module `rr_arb2`: request vector, priority pointer, and macro select in; one-hot grant and next pointer out.
- `dmem_arbiter` itself contains the muxing and response registers.

## Test plan
- Reset then idle: all gnt = 0, rvalid = 0, `mem_req_o` = 0, rdata = 0. After `rst_ni` rises, still 0 with no requests.
- m0 alone writes `0x0000_0001` to address 0x0 with be=`4'hF`: `m0_gnt_o` = 1 the same cycle, `mem_we_o` = 1, `m0_rvalid_o` = 1 the next cycle with rdata 0. Then an m1 read of 0x0 returns `0x0000_0001` one cycle after its gnt.
- Both masters request reads continuously at 0x4 and 0x8: grants alternate m0, m1, m0, m1. Rdata matches the memory preloaded values 0x37 and 0x59 respectively, and the rvalid id is never crossed.
- With `DMEM_ARB_FIXED_PRIO_EN` defined, both masters request for 4 cycles: m1 granted all 4 cycles, m0 gnt = 0 throughout.
- m0 granted a read, `rst_ni` pulsed low during the response cycle: `m0_rvalid_o` = 0 during reset and no rvalid follows. `prio_q` returns to master 0.
- m1 asserts req then drops it before gnt while m0 holds the grant: no m1 access reaches memory and `m1_rvalid_o` stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared types and constants for the two-master data-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int NUM_MASTERS  = 2;
    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DATA_W  = 32;

    typedef enum logic {
        MST_CORE = 1'b0,
        MST_AUX  = 1'b1
    } master_id_e;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0]   addr;
        logic                     we;
        logic [DMEM_DATA_W/8-1:0] be;
        logic [DMEM_DATA_W-1:0]   wdata;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way combinational arbiter; round-robin or fixed (master 1 wins).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   prio_i,
    input  logic                   fixed_prio_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   prio_next_o
);

    always_comb begin
        gnt_o       = '0;
        prio_next_o = prio_i;
        if (&req_i) begin
            if (fixed_prio_i || (prio_i == MST_AUX)) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end else begin
            gnt_o = req_i;
        end
        // Pointer moves to the loser of this cycle; holds when idle.
        if (gnt_o[1]) begin
            prio_next_o = MST_CORE;
        end else if (gnt_o[0]) begin
            prio_next_o = MST_AUX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares the single-port data memory between core LSU and aux master.
//          Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (master 1 wins).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic                   w_prio;
    logic                   w_prio_next;
    logic                   w_fixed;
    dmem_req_t              w_sel;

    logic resp_valid_q, resp_valid_d;
    logic resp_id_q,    resp_id_d;
    logic resp_we_q,    resp_we_d;

    // Requests are masked while in reset so nothing is granted then.
    assign w_req = {m1_req_i, m0_req_i} & {NUM_MASTERS{rst_ni}};

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_fixed = 1'b1;
    assign w_prio  = MST_CORE;
`else
    logic prio_q;

    assign w_fixed = 1'b0;
    assign w_prio  = prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= MST_CORE;
        end else begin
            prio_q <= w_prio_next;
        end
    end
`endif

    rr_arb2 u_rr_arb2 (
        .req_i        (w_req),
        .prio_i       (w_prio),
        .fixed_prio_i (w_fixed),
        .gnt_o        (w_gnt),
        .prio_next_o  (w_prio_next)
    );

    assign m0_gnt_o = w_gnt[0];
    assign m1_gnt_o = w_gnt[1];

    always_comb begin
        w_sel = '0;
        if (w_gnt[0]) begin
            w_sel = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
        end else if (w_gnt[1]) begin
            w_sel = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
        end
    end

    assign mem_req_o   = |w_gnt;
    assign mem_we_o    = w_sel.we;
    assign mem_addr_o  = w_sel.addr;
    assign mem_be_o    = w_sel.be;
    assign mem_wdata_o = w_sel.wdata;

    always_comb begin
        resp_valid_d = |w_gnt;
        resp_id_d    = resp_id_q;
        resp_we_d    = resp_we_q;
        if (|w_gnt) begin
            resp_id_d = w_gnt[1] ? MST_AUX : MST_CORE;
            resp_we_d = w_sel.we;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= MST_CORE;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_we_q    <= resp_we_d;
        end
    end

    assign m0_rvalid_o = resp_valid_q & (resp_id_q == MST_CORE);
    assign m1_rvalid_o = resp_valid_q & (resp_id_q == MST_AUX);
    assign m0_rdata_o  = (m0_rvalid_o && !resp_we_q) ? mem_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && !resp_we_q) ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed self-checking bench for dmem_arbiter with a 1-cycle memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic [31:0] mem [0:15];
    int          n_pass;
    int          n_total;

    dmem_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m0_req_i    (m0_req),
        .m0_gnt_o    (m0_gnt),
        .m0_addr_i   (m0_addr),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_wdata_i  (m0_wdata),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_gnt_o    (m1_gnt),
        .m1_addr_i   (m1_addr),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_wdata_i  (m1_wdata),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
            mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    endtask

    initial begin
        logic exp_w;
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1]    = 32'h37;
        mem[2]    = 32'h59;
        mem_rdata = '0;
        rst_n     = 1'b0;
        idle_all();

        // Reset: outputs idle, and a request during reset is not granted.
        tick();
        m0_req = 1'b1;
        #1;
        check("rst_gnt0",    {31'd0, m0_gnt},    32'd0);
        check("rst_gnt1",    {31'd0, m1_gnt},    32'd0);
        check("rst_memreq",  {31'd0, mem_req},   32'd0);
        check("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        check("rst_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        check("rst_rdata0",  m0_rdata,           32'd0);
        check("rst_rdata1",  m1_rdata,           32'd0);
        m0_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_memreq", {31'd0, mem_req},   32'd0);
        check("idle_gnt0",   {31'd0, m0_gnt},    32'd0);
        check("idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // m0 writes 1 to address 0, then m1 reads it back.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_be = 4'hF; m0_wdata = 32'h1;
        #1;
        check("wr_gnt0",   {31'd0, m0_gnt},  32'd1);
        check("wr_memwe",  {31'd0, mem_we},  32'd1);
        check("wr_wdata",  mem_wdata,        32'h1);
        check("wr_be",     {28'd0, mem_be},  32'hF);
        tick();
        idle_all();
        check("wr_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        check("wr_rdata0",  m0_rdata,           32'd0);
        check("wr_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        m1_req = 1'b1; m1_addr = 32'h0;
        #1;
        check("rd_gnt1",   {31'd0, m1_gnt},  32'd1);
        check("rd_memwe",  {31'd0, mem_we},  32'd0);
        tick();
        idle_all();
        check("rd_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        check("rd_rdata1",  m1_rdata,           32'h1);
        check("rd_rvalid0", {31'd0, m0_rvalid}, 32'd0);

        // Contention: both read continuously (pointer is back at master 0).
        m0_req = 1'b1; m0_addr = 32'h4;
        m1_req = 1'b1; m1_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = i[0];
`endif
            #1;
            check($sformatf("ct_gnt0_%0d", i), {31'd0, m0_gnt}, {31'd0, ~exp_w});
            check($sformatf("ct_gnt1_%0d", i), {31'd0, m1_gnt}, {31'd0, exp_w});
            check($sformatf("ct_addr_%0d", i), mem_addr, exp_w ? 32'h8 : 32'h4);
            tick();
            check($sformatf("ct_rv0_%0d", i), {31'd0, m0_rvalid}, {31'd0, ~exp_w});
            check($sformatf("ct_rv1_%0d", i), {31'd0, m1_rvalid}, {31'd0, exp_w});
            check($sformatf("ct_rd_%0d", i), exp_w ? m1_rdata : m0_rdata, exp_w ? 32'h59 : 32'h37);
            check($sformatf("ct_rdx_%0d", i), exp_w ? m0_rdata : m1_rdata, 32'h0);
        end
        idle_all();
        tick();

        // Reset during the response of an m0 read; pointer is at master 1 first.
        m0_req = 1'b1; m0_addr = 32'h4;
        #1;
        check("rr_gnt0", {31'd0, m0_gnt}, 32'd1);
        tick();
        idle_all();
        rst_n = 1'b0;
        #1;
        check("rr_rvalid0_in_rst", {31'd0, m0_rvalid}, 32'd0);
        check("rr_rdata0_in_rst",  m0_rdata,           32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_rvalid0_after", {31'd0, m0_rvalid}, 32'd0);
        check("rr_rvalid1_after", {31'd0, m1_rvalid}, 32'd0);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check("rr_prio_gnt1", {31'd0, m1_gnt}, 32'd1);
`else
        check("rr_prio_gnt0", {31'd0, m0_gnt}, 32'd1);
`endif
        idle_all();
        #1;
        tick();

        // m1 raises then withdraws a write while m0 wins; m1 must never reach memory.
        m0_req = 1'b1; m0_addr = 32'h8;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hC; m1_be = 4'hF; m1_wdata = 32'hDEAD_BEEF;
`endif
        #1;
        check("cx_gnt1",  {31'd0, m1_gnt}, 32'd0);
        check("cx_addr",  mem_addr,        32'h8);
        m1_req = 1'b0;
        #1;
        tick();
        idle_all();
        check("cx_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        check("cx_rdata0",  m0_rdata,           32'h59);
        check("cx_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        tick();
        check("cx_rvalid1_late", {31'd0, m1_rvalid}, 32'd0);
        check("cx_mem3",         mem[3],            32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
